// File: rtl/s444_bist_pkg.sv
// Shared types and helpers for the s444 BIST sequencer: FSM state encoding,
// the 16-bit polynomial used by both the pattern LFSR and the MISR, and seed fixup.
package s444_bist_pkg;

  localparam int SIG_W = 16;

  // Taps at bits 15, 13, 12 and 10.
  localparam logic [SIG_W-1:0] POLY16 = 16'hB400;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    DONE_S = 3'd4
  } state_e;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [SIG_W-1:0] seed_fix(input logic [SIG_W-1:0] s);
    return (s == '0) ? {{(SIG_W-1){1'b0}}, 1'b1} : s;
  endfunction

  function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] x);
    return {x[SIG_W-2:0], ^(x & POLY16)};
  endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit shift register used both as the pattern LFSR (xor_i tied 0) and as the
// output-compacting MISR. Load has priority over shift.
module bist_lfsr16
  import s444_bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [SIG_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic [SIG_W-1:0] xor_i,
  output logic [SIG_W-1:0] q_o
);

  logic [SIG_W-1:0] state_q;
  logic [SIG_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = load_val_i;
    end else if (en_i) begin
      state_d = lfsr_step(state_q) ^ xor_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RST_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign q_o = state_q;

endmodule

// File: rtl/s444_bist_ctrl.sv
// BIST sequencer for the s444 core: flush, PAT_CNT LFSR patterns, MISR compaction
// and golden compare. Optional ABORT input enabled by defining S444_BIST_ABORT_EN.
module s444_bist_ctrl
  import s444_bist_pkg::*;
#(
  parameter int               N_IN      = 3,
  parameter int               N_OUT     = 6,
  parameter int               PAT_CNT   = 256,
  parameter int               FLUSH_CYC = 2,
  parameter logic [N_IN-1:0]  FLUSH_VEC = 3'b001,
  parameter logic [SIG_W-1:0] SEED      = 16'hACE1
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [SIG_W-1:0] GOLDEN,
  input  logic [N_OUT-1:0] CUT_OUT,
`ifdef S444_BIST_ABORT_EN
  input  logic             ABORT,
`endif
  output logic [N_IN-1:0]  CUT_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [SIG_W-1:0] SIGNATURE,
  output state_e           DBG_STATE
);

  localparam int PC_W = $clog2(PAT_CNT + 1);
  localparam int FC_W = $clog2(FLUSH_CYC + 1);
  localparam logic [PC_W-1:0]  PAT_LAST   = PC_W'(PAT_CNT - 1);
  localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYC - 1);
  localparam logic [SIG_W-1:0] SEED_FIX   = seed_fix(SEED);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pat_cnt_q, pat_cnt_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [N_IN-1:0]  cut_in_q, cut_in_d;
  logic             busy_q, done_q;
  logic [SIG_W-1:0] lfsr_q;
  logic [SIG_W-1:0] misr_q;
  logic             abort_w, abort_hit;
  logic             busy_state;
  logic             lfsr_load, lfsr_en, misr_load, misr_en;

`ifdef S444_BIST_ABORT_EN
  assign abort_w = ABORT;
`else
  assign abort_w = 1'b0;
`endif

  assign busy_state = (state_q == FLUSH) || (state_q == RUN) || (state_q == DRAIN);
  assign abort_hit  = abort_w && busy_state;

  always_comb begin
    state_d     = state_q;
    pat_cnt_d   = pat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      IDLE, DONE_S: begin
        if (START) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d   = RUN;
          pat_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FC_W'(1);
        end
      end
      RUN: begin
        if (pat_cnt_q == PAT_LAST) begin
          state_d = DRAIN;
        end else begin
          pat_cnt_d = pat_cnt_q + PC_W'(1);
        end
      end
      DRAIN:   state_d = DONE_S;
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d = IDLE;
    end

    // CUT_IN is registered, so it is built from the value the LFSR will hold next cycle.
    cut_in_d = '0;
    if (state_d == FLUSH) begin
      cut_in_d = FLUSH_VEC;
    end else if (state_d == RUN) begin
      cut_in_d = (state_q == RUN) ? N_IN'(lfsr_step(lfsr_q)) : SEED_FIX[N_IN-1:0];
    end
  end

  assign lfsr_load = (state_q == FLUSH);
  assign lfsr_en   = (state_q == RUN);
  assign misr_load = (state_q == FLUSH);
  // The core answers one cycle late, so capture runs from the second RUN cycle through DRAIN.
  assign misr_en   = (((state_q == RUN) && (pat_cnt_q != '0)) || (state_q == DRAIN)) && !abort_hit;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      pat_cnt_q   <= '0;
      flush_cnt_q <= '0;
      cut_in_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_cnt_q   <= pat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      cut_in_q    <= cut_in_d;
      busy_q      <= (state_d == FLUSH) || (state_d == RUN) || (state_d == DRAIN);
      done_q      <= (state_d == DONE_S);
    end
  end

  bist_lfsr16 #(
    .RST_VAL (SEED_FIX)
  ) u_pat_lfsr (
    .clk_i      (CLOCK),
    .rst_ni     (RESET_N),
    .load_i     (lfsr_load),
    .load_val_i (SEED_FIX),
    .en_i       (lfsr_en),
    .xor_i      ({SIG_W{1'b0}}),
    .q_o        (lfsr_q)
  );

  bist_lfsr16 #(
    .RST_VAL ({SIG_W{1'b0}})
  ) u_misr (
    .clk_i      (CLOCK),
    .rst_ni     (RESET_N),
    .load_i     (misr_load),
    .load_val_i ({SIG_W{1'b0}}),
    .en_i       (misr_en),
    .xor_i      ({{(SIG_W-N_OUT){1'b0}}, CUT_OUT}),
    .q_o        (misr_q)
  );

  assign CUT_IN    = cut_in_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  // Combinational so a GOLDEN change while parked in DONE_S is reflected immediately.
  assign PASS      = done_q && (misr_q == GOLDEN);
  assign SIGNATURE = misr_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_s444_bist_ctrl.sv
// Bench for s444_bist_ctrl: a default-parameter instance driven by a small registered
// core model, and a PAT_CNT=4 / SEED=0 instance with its core outputs held at zero.
module tb_s444_bist_ctrl;
  import s444_bist_pkg::*;

  localparam int PAT_M = 256;
  localparam int FL    = 2;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic        start_m = 1'b0, start_s = 1'b0, abort_m = 1'b0;
  logic [15:0] golden_m = '0, golden_s = '0;
  logic [5:0]  cut_out_m = '0, cut_out_s = '0;
  logic [2:0]  cut_in_m, cut_in_s;
  logic        busy_m, done_m, pass_m, busy_s, done_s, pass_s;
  logic [15:0] sig_m, sig_s;
  state_e      dbg_m, dbg_s;

  s444_bist_ctrl #(.PAT_CNT(PAT_M)) u_dut (
    .CLOCK     (clk),
    .RESET_N   (rst_n),
    .START     (start_m),
    .GOLDEN    (golden_m),
    .CUT_OUT   (cut_out_m),
`ifdef S444_BIST_ABORT_EN
    .ABORT     (abort_m),
`endif
    .CUT_IN    (cut_in_m),
    .BUSY      (busy_m),
    .DONE      (done_m),
    .PASS      (pass_m),
    .SIGNATURE (sig_m),
    .DBG_STATE (dbg_m)
  );

  s444_bist_ctrl #(.PAT_CNT(4), .SEED(16'h0000)) u_small (
    .CLOCK     (clk),
    .RESET_N   (rst_n),
    .START     (start_s),
    .GOLDEN    (golden_s),
    .CUT_OUT   (cut_out_s),
`ifdef S444_BIST_ABORT_EN
    .ABORT     (1'b0),
`endif
    .CUT_IN    (cut_in_s),
    .BUSY      (busy_s),
    .DONE      (done_s),
    .PASS      (pass_s),
    .SIGNATURE (sig_s),
    .DBG_STATE (dbg_s)
  );

  function automatic logic [15:0] step16(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic logic [5:0] core_fn(input logic [2:0] x);
    return {x, x ^ 3'b110};
  endfunction

  // Registered stand-in for the core: one cycle from CUT_IN to CUT_OUT.
  always @(posedge clk) cut_out_m <= core_fn(cut_in_m);

  function automatic logic [15:0] model_sig(input logic [15:0] seed, input int n);
    logic [15:0] l, m;
    l = (seed == 16'h0000) ? 16'h0001 : seed;
    m = 16'h0000;
    for (int k = 0; k < n; k++) begin
      m = step16(m) ^ {10'b0, core_fn(l[2:0])};
      l = step16(l);
    end
    return m;
  endfunction

  // Scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_m_q[$];
  logic [15:0] exp_s_q[$];
  logic done_m_d = 1'b0, done_s_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (done_m && !done_m_d) begin
      if (exp_m_q.size() == 0) begin
        n_checks++;
        $display("FAIL sig_m_unexpected: got 0x%0h, expected no completion", sig_m);
      end else begin
        check("sig_m", sig_m, exp_m_q.pop_front());
      end
    end
    if (done_s && !done_s_d) begin
      if (exp_s_q.size() == 0) begin
        n_checks++;
        $display("FAIL sig_s_unexpected: got 0x%0h, expected no completion", sig_s);
      end else begin
        check("sig_s", sig_s, exp_s_q.pop_front());
      end
    end
    done_m_d = done_m;
    done_s_d = done_s;
  end

  // Driver: stop_kind bit0 = pull reset, bit1 = assert ABORT, at busy cycle stop_cyc.
  logic [2:0] cut_log [4];

  task automatic run_main(input int stop_cyc, input int stop_kind,
                          output int busy_cnt, output int done_cyc, output int cut_err);
    logic [15:0] lf;
    logic [2:0]  exp_in;
    lf = 16'hACE1;
    busy_cnt = 0;
    done_cyc = 0;
    cut_err  = 0;
    @(negedge clk); start_m = 1'b1;
    @(negedge clk); start_m = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (c <= 4) cut_log[c-1] = cut_in_m;
      if (busy_m) busy_cnt++;
      if (c <= FL) exp_in = 3'b001;
      else if (c <= FL + PAT_M) begin
        exp_in = lf[2:0];
        lf = step16(lf);
      end else exp_in = 3'b000;
      if (busy_m && (cut_in_m !== exp_in)) cut_err++;
      if (done_m) begin
        done_cyc = c;
        break;
      end
      if (c == stop_cyc) begin
        if (stop_kind[0]) rst_n = 1'b0;
        if (stop_kind[1]) abort_m = 1'b1;
        @(negedge clk);
        rst_n   = 1'b1;
        abort_m = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic        bl [21];
  logic        dl [21];
  logic [2:0]  cl [21];

  initial begin
    int busy_cnt, done_cyc, cut_err, bsum;
    logic [15:0] exp_sig;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cut_in", cut_in_m, 3'b000);
    check("rst_busy", busy_m, 1'b0);
    check("rst_done", done_m, 1'b0);
    check("rst_pass", pass_m, 1'b0);
    check("rst_sig", sig_m, 16'h0000);
    check("rst_state", dbg_m, IDLE);
    check("rst_busy_s", busy_s, 1'b0);
    rst_n = 1'b1;

    // Full default run from reset
    exp_sig  = model_sig(16'hACE1, PAT_M);
    golden_m = exp_sig;
    exp_m_q.push_back(exp_sig);
    run_main(0, 0, busy_cnt, done_cyc, cut_err);
    check("busy_width", busy_cnt, 259);
    check("done_cycle", done_cyc, 260);
    check("cut_in_seq", cut_err, 0);
    check("flush_vec_c1", cut_log[0], 3'b001);
    check("flush_vec_c2", cut_log[1], 3'b001);
    check("run1_cut_in", cut_log[2], 3'b001);
    check("run2_cut_in", cut_log[3], 3'b011);
    check("done_pass", pass_m, 1'b1);
    check("done_state", dbg_m, DONE_S);
    check("done_cut_in", cut_in_m, 3'b000);
    golden_m = exp_sig ^ 16'h0001;
    #1;
    check("done_pass_bad_golden", pass_m, 1'b0);
    golden_m = exp_sig;

    // Reset at RUN cycle 10, then a full run from reset
    run_main(FL + 10, 1, busy_cnt, done_cyc, cut_err);
    check("midrst_busy_before", busy_cnt, FL + 10);
    check("midrst_cut_in", cut_in_m, 3'b000);
    check("midrst_busy", busy_m, 1'b0);
    check("midrst_done", done_m, 1'b0);
    check("midrst_pass", pass_m, 1'b0);
    check("midrst_sig", sig_m, 16'h0000);
    check("midrst_state", dbg_m, IDLE);
    exp_m_q.push_back(exp_sig);
    run_main(0, 0, busy_cnt, done_cyc, cut_err);
    check("rerun_busy_width", busy_cnt, 259);
    check("rerun_done_cycle", done_cyc, 260);

    // Restart straight from DONE_S: MISR must be cleared by the flush
    exp_m_q.push_back(exp_sig);
    run_main(0, 0, busy_cnt, done_cyc, cut_err);
    check("restart_busy_width", busy_cnt, 259);
    check("restart_cut_in_seq", cut_err, 0);
    check("restart_pass", pass_m, 1'b1);

`ifdef S444_BIST_ABORT_EN
    run_main(FL + 5, 2, busy_cnt, done_cyc, cut_err);
    check("abort_busy", busy_m, 1'b0);
    check("abort_done", done_m, 1'b0);
    check("abort_cut_in", cut_in_m, 3'b000);
    check("abort_state", dbg_m, IDLE);
    run_main(FL + 5, 3, busy_cnt, done_cyc, cut_err);
    check("abort_rst_sig", sig_m, 16'h0000);
    check("abort_rst_busy", busy_m, 1'b0);
    check("abort_rst_state", dbg_m, IDLE);
`endif

    // Small instance: START held high, zero core outputs, SEED=0
    golden_s = 16'h0000;
    exp_s_q.push_back(16'h0000);
    exp_s_q.push_back(16'h0000);
    @(negedge clk); start_s = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bl[c] = busy_s;
      dl[c] = done_s;
      cl[c] = cut_in_s;
      if (c == 9) start_s = 1'b0;
    end
    bsum = 0;
    for (int c = 1; c <= 8; c++) if (bl[c]) bsum++;
    check("s_busy_width", bsum, 7);
    check("s_done_c8", dl[8], 1'b1);
    check("s_busy_c8", bl[8], 1'b0);
    check("s_restart_busy_c9", bl[9], 1'b1);
    check("s_restart_done_c9", dl[9], 1'b0);
    check("s_flush_c9", cl[9], 3'b001);
    check("s_seed0_run1", cl[3], 3'b001);
    check("s_seed0_run2", cl[4], 3'b010);
    check("s_done_c16", dl[16], 1'b1);
    check("s_done_hold_c20", dl[20], 1'b1);
    check("s_pass", pass_s, 1'b1);
    golden_s = 16'h0001;
    #1;
    check("s_pass_bad_golden", pass_s, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_m_drained", exp_m_q.size(), 0);
    check("sb_s_drained", exp_s_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
